ahb_dls_fault_monitor: RTL and testbench
========================================

# ahb_dls_fault_monitor

Downstream consumer of the lockstep VGA's `DLS_ERROR` mismatch flag. It filters transient mismatches through a persistence FSM, declares a sticky fault, counts mismatch cycles, timestamps the first mismatch and raises an interrupt. The register file is exposed as an AHB-Lite slave on the same bus as the VGA peripheral, so firmware can inspect and clear faults.

## Interface
- `THRESH`, default 4: consecutive `DLS_ERROR` cycles required to declare a fault. Legal range 1..255.
- `CNT_W`, default 16: width of the saturating mismatch counter, ≤32.
- `HCLK` in 1: clock.
- `HRESET` in 1: reset. Asynchronous and active-high.
- `HADDR` in 32: AHB address. Only `[3:2]` are decoded.
- `HWDATA` in 32: AHB write data.
- `HREADY` in 1: AHB bus ready.
- `HWRITE` in 1: AHB write.
- `HTRANS` in 2: AHB transfer type.
- `HSEL` in 1: slave select.
- `DLS_ERROR` in 1: registered mismatch flag from the lockstep VGA pair.
- `HRDATA` out 32: read data.
- `HREADYOUT` out 1: tied 1, zero wait states.
- `FAULT` out 1: high while the FSM is in FAULT.
- `IRQ` out 1: `FAULT & CTRL.IRQEN`.

## Operation
Register map:
- 0x0 CTRL (RW).
  - bit0 EN.
  - bit1 IRQEN.
  - Reset value 0x3.
- 0x4 STATUS.
  - bit0 FAULT: W1C.
  - bits[2:1] state: RO, OK=0, SUSPECT=1, FAULT=2.
  - bits[15:8] run count: RO.
- 0x8 ERRCNT (RO value): any write clears ERRCNT and FIRST_TS.
- 0xC FIRST_TS (RO): cycle timestamp of the first counted mismatch since the last clear.
- Unused bits read 0.

Persistence FSM. `run` is an 8-bit counter of consecutive mismatch cycles.
- OK:
  - `EN & DLS_ERROR` with THRESH=1 → FAULT.
  - `EN & DLS_ERROR` otherwise → SUSPECT, run=1.
- SUSPECT:
  - `!DLS_ERROR` or `!EN` → OK, run=0.
  - `DLS_ERROR` with run+1==THRESH → FAULT.
  - `DLS_ERROR` otherwise → run+1.
- FAULT:
  - Sticky; EN has no effect.
  - A write of STATUS with bit0=1 → OK, run=0.
  - If a set condition is not possible in FAULT, a clear always leaves FAULT.

Counters:
- Timestamp: free-running 32-bit cycle counter, wraps 0xFFFFFFFF→0.
- ERRCNT:
  - Increments on each cycle with `EN & DLS_ERROR`, in any state.
  - Saturates at 2^CNT_W−1.
- FIRST_TS: loaded with the timestamp when `EN & DLS_ERROR & ERRCNT==0`.
- Simultaneous ERRCNT clear write and counted mismatch: ERRCNT=1 and FIRST_TS reloads. The increment is applied after the clear.

AHB-Lite:
- Address phase is accepted when `HSEL & HREADY & HTRANS[1]`. Address, write and valid are registered.
- Writes take effect at the end of the data phase using `HWDATA`.
- `HRDATA` is decoded combinationally from the registered address during the data phase. It is 0 when no read is in its data phase.
- Back-to-back transfers are supported. A read following a write to the same register returns the new value.

## Timing
- Reset values: every output is 0 except `HREADYOUT`=1.
  - FSM=OK, run=0, ERRCNT=0, FIRST_TS=0, timestamp=0, CTRL=0x3.
- Reset is asynchronous. Assertion mid-operation clears all state immediately, including a sticky FAULT.
- FSM, ERRCNT and FIRST_TS update on the HCLK edge that samples `DLS_ERROR`.
- Latency: `FAULT` and `IRQ` rise on the edge where the THRESH-th consecutive mismatch is sampled, as registered outputs.
- Clearing via STATUS W1C:
  - `FAULT` falls on the edge ending the write data phase.
  - A mismatch sampled on that same edge is evaluated from OK, so with THRESH=1 FAULT stays 1.
- `IRQ` follows IRQEN combinationally. Toggling IRQEN does not affect `FAULT`.
- Run count saturates at THRESH internally and never wraps.

## Structure
- Package `ahb_dls_pkg`:
  - State enum `dls_state_t` (OK/SUSPECT/FAULT).
  - Register offset constants.
  - CTRL/STATUS bit index constants.
- Optional sub-module `ahb_slave_regif`: AHB-Lite address-phase capture plus read/write strobe generation. Reusable by other peripherals.
- Target size: 150–250 lines.

## Test plan
- Reset, then read all four registers → CTRL=0x3, others 0. FAULT=0, IRQ=0, HREADYOUT=1.
- THRESH=4, drive DLS_ERROR high for 3 cycles then low → state returns to OK, FAULT=0, ERRCNT=3, FIRST_TS = timestamp of the first high cycle.
- THRESH=4, drive DLS_ERROR high for 4 cycles → FAULT and IRQ high on the 4th sampling edge. Then write STATUS=0x1 → FAULT=0, ERRCNT unchanged.
- CTRL=0x1 (IRQEN=0), force a fault → FAULT=1, IRQ=0. Then write CTRL=0x3 → IRQ=1 combinationally.
- CTRL=0x0 with DLS_ERROR held high for 10 cycles → state stays OK, ERRCNT=0.
- Write ERRCNT on the same cycle as a counted mismatch → ERRCNT=1 and FIRST_TS=current timestamp. Assert HRESET mid-SUSPECT → all state returns to reset values asynchronously.

Source files
------------

// File: rtl/ahb_dls_pkg.sv
// Shared types and register-map constants for the lockstep fault monitor.
// The register index is the word offset taken from HADDR[3:2].
package ahb_dls_pkg;

  typedef enum logic [1:0] {
    DLS_OK      = 2'd0,
    DLS_SUSPECT = 2'd1,
    DLS_FAULT   = 2'd2
  } dls_state_t;

  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;
  localparam logic [1:0] REG_ERRCNT   = 2'd2;
  localparam logic [1:0] REG_FIRST_TS = 2'd3;

  localparam logic [31:0] OFFS_CTRL     = 32'h0000_0000;
  localparam logic [31:0] OFFS_STATUS   = 32'h0000_0004;
  localparam logic [31:0] OFFS_ERRCNT   = 32'h0000_0008;
  localparam logic [31:0] OFFS_FIRST_TS = 32'h0000_000C;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_IRQEN_BIT   = 1;
  localparam int STATUS_FAULT_BIT = 0;
  localparam int STATUS_STATE_LSB = 1;
  localparam int STATUS_RUN_LSB   = 8;

  localparam logic [1:0] CTRL_RESET = 2'b11;

endpackage

// File: rtl/ahb_slave_regif.sv
// AHB-Lite address-phase capture for a zero-wait-state register slave.
// Produces a write strobe at the end of the data phase and a read-active flag during it.
module ahb_slave_regif (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hsel_i,
  input  logic        hready_i,
  input  logic [1:0]  htrans_i,
  input  logic        hwrite_i,
  input  logic [31:0] haddr_i,
  output logic        wrEn_o,
  output logic        rdEn_o,
  output logic [1:0]  regIdx_o
);

  logic       valid_q;
  logic       write_q;
  logic [1:0] idx_q;
  logic       accept;
  logic       unusedBits;

  assign accept     = hsel_i & hready_i & htrans_i[1];
  assign unusedBits = ^{haddr_i[31:4], haddr_i[1:0], htrans_i[0]};

  // The address phase only advances when the bus is ready, so a stalled
  // data phase of another slave never corrupts our captured transfer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      write_q <= 1'b0;
      idx_q   <= 2'd0;
    end else if (hready_i) begin
      valid_q <= accept;
      write_q <= hwrite_i;
      idx_q   <= haddr_i[3:2];
    end
  end

  assign wrEn_o   = valid_q & write_q & hready_i;
  assign rdEn_o   = valid_q & ~write_q;
  assign regIdx_o = idx_q;

endmodule

// File: rtl/ahb_dls_fault_monitor.sv
// Filters lockstep mismatch flags into a sticky fault with counters, timestamp and IRQ,
// exposed to firmware through an AHB-Lite register slave.
module ahb_dls_fault_monitor
  import ahb_dls_pkg::*;
#(
  parameter int THRESH = 4,
  parameter int CNT_W  = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic        HSEL,
  input  logic        DLS_ERROR,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        FAULT,
  output logic        IRQ
);

  localparam logic [7:0]       THRESH_V = 8'(THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             wrEn;
  logic             rdEn;
  logic [1:0]       regIdx;

  logic [1:0]       ctrl_q, ctrl_d;
  dls_state_t       state_q, state_d;
  logic [7:0]       run_q, run_d;
  logic [CNT_W-1:0] errCnt_q, errCnt_d;
  logic [31:0]      firstTs_q, firstTs_d;
  logic [31:0]      timeStamp_q;

  dls_state_t       okState;
  logic [7:0]       okRun;
  logic [CNT_W-1:0] errBase;
  logic             counted;
  logic             wrCtrl;
  logic             clrFault;
  logic             clrCnt;
  logic             faultActive;
  logic [31:0]      rdData;
  logic             unusedWdata;

  ahb_slave_regif u_regif (
    .clk_i    (HCLK),
    .rst_i    (HRESET),
    .hsel_i   (HSEL),
    .hready_i (HREADY),
    .htrans_i (HTRANS),
    .hwrite_i (HWRITE),
    .haddr_i  (HADDR),
    .wrEn_o   (wrEn),
    .rdEn_o   (rdEn),
    .regIdx_o (regIdx)
  );

  assign unusedWdata = ^HWDATA[31:2];
  assign counted     = ctrl_q[CTRL_EN_BIT] & DLS_ERROR;
  assign wrCtrl      = wrEn & (regIdx == REG_CTRL);
  assign clrFault    = wrEn & (regIdx == REG_STATUS) & HWDATA[STATUS_FAULT_BIT];
  assign clrCnt      = wrEn & (regIdx == REG_ERRCNT);
  assign faultActive = (state_q == DLS_FAULT);

  // Transition out of OK; also reused when a fault is cleared so a mismatch
  // on the clearing edge is judged as if the FSM were already in OK.
  always_comb begin
    okState = DLS_OK;
    okRun   = 8'd0;
    if (counted) begin
      if (THRESH_V == 8'd1) begin
        okState = DLS_FAULT;
        okRun   = THRESH_V;
      end else begin
        okState = DLS_SUSPECT;
        okRun   = 8'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    unique case (state_q)
      DLS_OK: begin
        state_d = okState;
        run_d   = okRun;
      end
      DLS_SUSPECT: begin
        if (!counted) begin
          state_d = DLS_OK;
          run_d   = 8'd0;
        end else if ((run_q + 8'd1) >= THRESH_V) begin
          state_d = DLS_FAULT;
          run_d   = THRESH_V;
        end else begin
          run_d = run_q + 8'd1;
        end
      end
      DLS_FAULT: begin
        if (clrFault) begin
          state_d = okState;
          run_d   = okRun;
        end
      end
      default: begin
        state_d = DLS_OK;
        run_d   = 8'd0;
      end
    endcase
  end

  // A clear write and a counted mismatch on the same edge apply clear first.
  always_comb begin
    errBase   = clrCnt ? '0 : errCnt_q;
    errCnt_d  = errBase;
    firstTs_d = clrCnt ? 32'd0 : firstTs_q;
    if (counted) begin
      if (errBase != CNT_MAX) begin
        errCnt_d = errBase + CNT_W'(1);
      end
      if (errBase == '0) begin
        firstTs_d = timeStamp_q;
      end
    end
  end

  assign ctrl_d = wrCtrl ? HWDATA[1:0] : ctrl_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ctrl_q      <= CTRL_RESET;
      state_q     <= DLS_OK;
      run_q       <= 8'd0;
      errCnt_q    <= '0;
      firstTs_q   <= 32'd0;
      timeStamp_q <= 32'd0;
    end else begin
      ctrl_q      <= ctrl_d;
      state_q     <= state_d;
      run_q       <= run_d;
      errCnt_q    <= errCnt_d;
      firstTs_q   <= firstTs_d;
      timeStamp_q <= timeStamp_q + 32'd1;
    end
  end

  always_comb begin
    rdData = 32'd0;
    if (rdEn) begin
      unique case (regIdx)
        REG_CTRL: rdData[1:0] = ctrl_q;
        REG_STATUS: begin
          rdData[STATUS_FAULT_BIT]        = faultActive;
          rdData[STATUS_STATE_LSB +: 2]   = state_q;
          rdData[STATUS_RUN_LSB +: 8]     = run_q;
        end
        REG_ERRCNT:   rdData = 32'(errCnt_q);
        REG_FIRST_TS: rdData = firstTs_q;
        default:      rdData = 32'd0;
      endcase
    end
  end

  assign HRDATA    = rdData;
  assign HREADYOUT = 1'b1;
  assign FAULT     = faultActive;
  assign IRQ       = faultActive & ctrl_q[CTRL_IRQEN_BIT];

endmodule

// File: tb/tb_ahb_dls_fault_monitor.sv
// Directed bench for ahb_dls_fault_monitor; read results are checked through an
// expected-value queue drained at each read data phase.
module tb_ahb_dls_fault_monitor;
  import ahb_dls_pkg::*;

  localparam int THRESH = 4;
  localparam int CNT_W  = 4;

  logic        HCLK;
  logic        HRESET;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic        HSEL;
  logic        DLS_ERROR;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        FAULT;
  logic        IRQ;

  typedef struct {
    string       tag;
    logic [31:0] expVal;
  } expItem_t;

  expItem_t    expQ[$];
  expItem_t    item;
  int          assertCount = 0;
  int          failCount   = 0;
  logic [31:0] tbCycle;
  logic        rdPhase;
  logic [31:0] t0, tA, tB;

  ahb_dls_fault_monitor #(.THRESH(THRESH), .CNT_W(CNT_W)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HADDR     (HADDR),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HWRITE    (HWRITE),
    .HTRANS    (HTRANS),
    .HSEL      (HSEL),
    .DLS_ERROR (DLS_ERROR),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT),
    .FAULT     (FAULT),
    .IRQ       (IRQ)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Reference cycle count: equals the DUT timestamp at every falling edge.
  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) tbCycle <= 32'd0;
    else        tbCycle <= tbCycle + 32'd1;
  end

  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET)      rdPhase <= 1'b0;
    else if (HREADY) rdPhase <= HSEL & HTRANS[1] & ~HWRITE;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expVal);
    assertCount++;
    assert (obs === expVal) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expVal);
    end
  endtask

  // Read data phases pop the scoreboard; other cycles must read back zero.
  always @(negedge HCLK) begin
    if (!HRESET) begin
      if (rdPhase) begin
        if (expQ.size() == 0) begin
          assertCount++;
          failCount++;
          $error("[TB] FAIL sb_underflow: observed 0x%08h expected no read", HRDATA);
        end else begin
          item = expQ.pop_front();
          checkOutput(item.tag, HRDATA, item.expVal);
        end
      end else begin
        checkOutput("hrdata_idle", HRDATA, 32'h0);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge HCLK);
  endtask

  task automatic applyStimulus(input logic dls, input int cycles);
    DLS_ERROR = dls;
    tick(cycles);
  endtask

  task automatic ahbWrite(input logic [31:0] addr, input logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'h0; HWDATA = data;
  endtask

  task automatic ahbRead(input logic [31:0] addr, input logic [31:0] expVal, input string tag);
    expItem_t e;
    e.tag = tag;
    e.expVal = expVal;
    expQ.push_back(e);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00; HADDR = 32'h0;
  endtask

  initial begin
    HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    HADDR = 32'h0; HWDATA = 32'h0; HREADY = 1'b1; DLS_ERROR = 1'b0;
    tick(2);
    checkOutput("rst_fault", FAULT, 1'b0);
    checkOutput("rst_irq", IRQ, 1'b0);
    checkOutput("rst_hreadyout", HREADYOUT, 1'b1);
    checkOutput("rst_hrdata", HRDATA, 32'h0);
    HRESET = 1'b0;

    ahbRead(OFFS_CTRL, 32'h3, "rst_ctrl");
    ahbRead(OFFS_STATUS, 32'h0, "rst_status");
    ahbRead(OFFS_ERRCNT, 32'h0, "rst_errcnt");
    ahbRead(OFFS_FIRST_TS, 32'h0, "rst_first_ts");
    tick();

    // Three-cycle burst stays below threshold
    t0 = tbCycle;
    applyStimulus(1'b1, 1);
    ahbRead(OFFS_STATUS, 32'h0000_0202, "suspect_run2");
    tick();
    applyStimulus(1'b0, 1);
    checkOutput("short_burst_fault", FAULT, 1'b0);
    ahbRead(OFFS_STATUS, 32'h0, "short_burst_status");
    ahbRead(OFFS_ERRCNT, 32'd3, "short_burst_errcnt");
    ahbRead(OFFS_FIRST_TS, t0, "short_burst_first_ts");

    // Four-cycle burst reaches threshold
    applyStimulus(1'b1, 3);
    checkOutput("fault_before_thresh", FAULT, 1'b0);
    tick();
    checkOutput("fault_at_thresh", FAULT, 1'b1);
    checkOutput("irq_at_thresh", IRQ, 1'b1);
    DLS_ERROR = 1'b0;
    ahbRead(OFFS_STATUS, 32'h0000_0405, "fault_status");
    ahbRead(OFFS_ERRCNT, 32'd7, "fault_errcnt");
    ahbWrite(OFFS_STATUS, 32'h1);
    tick();
    checkOutput("w1c_fault", FAULT, 1'b0);
    checkOutput("w1c_irq", IRQ, 1'b0);
    ahbRead(OFFS_ERRCNT, 32'd7, "errcnt_after_w1c");
    ahbRead(OFFS_STATUS, 32'h0, "status_after_w1c");
    ahbRead(OFFS_FIRST_TS, t0, "first_ts_held");

    // IRQ gating by IRQEN
    ahbWrite(OFFS_CTRL, 32'h1);
    ahbRead(OFFS_CTRL, 32'h1, "ctrl_read_after_write");
    applyStimulus(1'b1, 4);
    checkOutput("irqen0_fault", FAULT, 1'b1);
    checkOutput("irqen0_irq", IRQ, 1'b0);
    DLS_ERROR = 1'b0;
    ahbWrite(OFFS_CTRL, 32'h3);
    tick();
    checkOutput("irqen1_irq", IRQ, 1'b1);
    ahbWrite(OFFS_CTRL, 32'h1);
    tick();
    checkOutput("irqen_off_irq", IRQ, 1'b0);
    checkOutput("irqen_off_fault", FAULT, 1'b1);
    ahbWrite(OFFS_CTRL, 32'h3);
    ahbWrite(OFFS_STATUS, 32'h0);
    tick();
    checkOutput("w0_no_clear", FAULT, 1'b1);
    checkOutput("w0_irq", IRQ, 1'b1);

    // Clear coincident with a mismatch restarts from OK
    ahbWrite(OFFS_STATUS, 32'h1);
    DLS_ERROR = 1'b1;
    tick();
    checkOutput("w1c_with_mismatch", FAULT, 1'b0);
    ahbRead(OFFS_STATUS, 32'h0000_0202, "w1c_eval_from_ok");
    DLS_ERROR = 1'b0;
    tick();

    // Disabled monitor ignores mismatches
    ahbWrite(OFFS_ERRCNT, 32'h0);
    ahbWrite(OFFS_CTRL, 32'h0);
    tick();
    ahbRead(OFFS_ERRCNT, 32'h0, "errcnt_cleared");
    ahbRead(OFFS_FIRST_TS, 32'h0, "first_ts_cleared");
    applyStimulus(1'b1, 10);
    ahbRead(OFFS_STATUS, 32'h0, "disabled_status");
    ahbRead(OFFS_ERRCNT, 32'h0, "disabled_errcnt");
    checkOutput("disabled_fault", FAULT, 1'b0);
    DLS_ERROR = 1'b0;

    // Clear write on the same edge as a counted mismatch
    ahbWrite(OFFS_CTRL, 32'h3);
    tick();
    tA = tbCycle;
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 3);
    ahbRead(OFFS_FIRST_TS, tA, "first_ts_a");
    ahbRead(OFFS_ERRCNT, 32'd1, "errcnt_single");
    ahbWrite(OFFS_ERRCNT, 32'h0);
    tB = tbCycle;
    DLS_ERROR = 1'b1;
    tick();
    DLS_ERROR = 1'b0;
    ahbRead(OFFS_ERRCNT, 32'd1, "clr_and_count");
    ahbRead(OFFS_FIRST_TS, tB, "first_ts_reload");

    // Counter saturation and upper address bits ignored
    applyStimulus(1'b1, 20);
    DLS_ERROR = 1'b0;
    ahbRead(OFFS_ERRCNT, 32'd15, "errcnt_saturates");
    checkOutput("sat_fault", FAULT, 1'b1);
    ahbWrite(OFFS_STATUS, 32'h1);
    tick();
    ahbRead(32'hFFFF_FFF0, 32'h3, "alias_ctrl");

    // Asynchronous reset while in SUSPECT
    ahbWrite(OFFS_CTRL, 32'h1);
    tick();
    applyStimulus(1'b1, 2);
    #2 HRESET = 1'b1;
    #1;
    checkOutput("async_rst_suspect_fault", FAULT, 1'b0);
    checkOutput("async_rst_suspect_hrdata", HRDATA, 32'h0);
    DLS_ERROR = 1'b0;
    tick();
    HRESET = 1'b0;
    ahbRead(OFFS_CTRL, 32'h3, "post_rst_ctrl");
    ahbRead(OFFS_STATUS, 32'h0, "post_rst_status");
    ahbRead(OFFS_ERRCNT, 32'h0, "post_rst_errcnt");
    ahbRead(OFFS_FIRST_TS, 32'h0, "post_rst_first_ts");

    // Asynchronous reset clears a sticky fault
    applyStimulus(1'b1, 4);
    checkOutput("pre_rst_fault", FAULT, 1'b1);
    checkOutput("pre_rst_irq", IRQ, 1'b1);
    DLS_ERROR = 1'b0;
    #2 HRESET = 1'b1;
    #1;
    checkOutput("async_rst_fault", FAULT, 1'b0);
    checkOutput("async_rst_irq", IRQ, 1'b0);
    tick();
    HRESET = 1'b0;
    tick(2);
    ahbRead(OFFS_STATUS, 32'h0, "status_after_fault_rst");
    tick();

    checkOutput("sb_drained", expQ.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
